// File: rtl/spi_frame_pkg.sv
// ============================================================================
// Module      : spi_frame_pkg
// Description : Shared constants and state encoding for the SPI frame reader.
//               FRAME_BITS      - SPI_clk rises per frame
//               DATA_BITS       - right-justified sample width
//               MIN_HALF_PERIOD - smallest half-period that still lets the
//                                 slave's 3-flop synchroniser settle MISO
//               MIN_GAP         - smallest cs-high gap the slave needs to
//                                 reload its next sample
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_frame_pkg;

    localparam int FRAME_BITS      = 16;
    localparam int DATA_BITS       = 12;
    localparam int MIN_HALF_PERIOD = 4;
    localparam int MIN_GAP         = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } spi_rd_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_half_tick.sv
// ============================================================================
// Module      : spi_half_tick
// Description : Phase timer for the SPI frame reader. Reloaded on every state
//               entry with either HALF_PERIOD or GAP_CYCLES and counts down;
//               o_tick is high on the last cycle of the phase.
// Ports       : clk         - system clock
//               rst_n       - synchronous active-low reset
//               i_load      - a state transition happens on this edge
//               i_load_gap  - the state being entered is GAP
//               o_tick      - last cycle of the current phase
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_half_tick #(
    parameter int HALF_PERIOD = 8,
    parameter int GAP_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_load_gap,
    output logic o_tick
);

    localparam int MAX_LEN = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN);

    // Reload with length-1 so the phase lasts exactly 'length' cycles,
    // the final one being the cycle where the counter reads zero.
    localparam logic [CNT_W-1:0] c_half_reload = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_gap_reload  = CNT_W'(GAP_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_gap ? c_gap_reload : c_half_reload;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/spi_frame_reader.sv
// ============================================================================
// Module      : spi_frame_reader
// Description : SPI mode-0 master reading 16-bit frames (12-bit sample,
//               upper nibble expected zero) and presenting each sample as a
//               parallel word with a one-cycle valid strobe.
// Ports       : clk         - system clock
//               rst_n       - synchronous active-low reset
//               start       - one-frame request, honoured only in IDLE
//               continuous  - repeat frames back-to-back while high
//               MISO        - serial data from slave, MSB first
//               SPI_clk     - SPI clock, idles low
//               cs          - chip select, active-low
//               data_out    - last received 12-bit sample
//               data_valid  - one-cycle pulse when data_out updates
//               frame_err   - upper nibble of last frame was non-zero
//               busy        - high in every state except IDLE
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_reader
    import spi_frame_pkg::*;
#(
    parameter int HALF_PERIOD = 8,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 MISO,
    output logic                 SPI_clk,
    output logic                 cs,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    generate
        if (HALF_PERIOD < MIN_HALF_PERIOD || GAP_CYCLES < MIN_GAP) begin : g_bad_params
            $error("spi_frame_reader: HALF_PERIOD and GAP_CYCLES must both be >= 4");
        end
    endgenerate

    localparam logic [4:0] c_frame_bits = 5'(FRAME_BITS);

    spi_rd_state_t         r_state;
    spi_rd_state_t         w_next;
    logic                  w_tick;
    logic                  w_load;
    logic                  w_rise;
    logic                  w_frame_done;
    logic [4:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start || continuous) w_next = ST_SETUP;
            ST_SETUP: if (w_tick)              w_next = ST_HIGH;
            ST_HIGH:  if (w_tick)              w_next = ST_LOW;
            ST_LOW: begin
                if (w_tick) begin
                    w_next = (r_bit_cnt < c_frame_bits) ? ST_HIGH : ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_next = continuous ? ST_SETUP : ST_IDLE;
                end
            end
            default:                           w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore): pins follow the state register directly so a
    // reset edge returns cs/SPI_clk to idle immediately.
    // ------------------------------------------------------------------
    always_comb begin
        cs      = 1'b1;
        SPI_clk = 1'b0;
        busy    = 1'b1;
        case (r_state)
            ST_IDLE:  busy    = 1'b0;
            ST_SETUP: cs      = 1'b0;
            ST_HIGH: begin
                cs      = 1'b0;
                SPI_clk = 1'b1;
            end
            ST_LOW:   cs      = 1'b0;
            ST_GAP:   cs      = 1'b1;
            default:  busy    = 1'b0;
        endcase
    end

    // Every transition changes state, so any change reloads the phase timer.
    assign w_load       = (w_next != r_state);
    assign w_rise       = (w_next == ST_HIGH) && (r_state != ST_HIGH);
    assign w_frame_done = (r_state == ST_LOW) && (w_next == ST_GAP);

    spi_half_tick #(
        .HALF_PERIOD (HALF_PERIOD),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_half_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_gap (w_next == ST_GAP),
        .o_tick     (w_tick)
    );

    // ------------------------------------------------------------------
    // Shift register, bit counter and result registers. MISO is captured
    // on the same edge that drives SPI_clk high, i.e. the slave's data is
    // sampled as the rising edge is launched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            data_out   <= '0;
            frame_err  <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if (w_rise) begin
                r_shift   <= {r_shift[FRAME_BITS-2:0], MISO};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (r_state == ST_SETUP) begin
                r_bit_cnt <= '0;
            end

            data_valid <= w_frame_done;
            if (w_frame_done) begin
                data_out  <= r_shift[DATA_BITS-1:0];
                frame_err <= |r_shift[FRAME_BITS-1:DATA_BITS];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_reader.sv
// ============================================================================
// Module      : tb_spi_frame_reader
// Description : Self-checking bench for spi_frame_reader with a behavioural
//               SPI slave (3-flop synchronised, shifts on SPI_clk fall,
//               reloads while cs is high) and a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_frame_reader;

    localparam int HP  = 8;
    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic        MISO;
    logic        SPI_clk;
    logic        cs;
    logic [11:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        busy;

    int checks   = 0;
    int errors   = 0;
    int cycle_no = 0;
    int dv_count = 0;

    logic [12:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    spi_frame_reader #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .MISO       (MISO),
        .SPI_clk    (SPI_clk),
        .cs         (cs),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // ---------------- slave model ----------------
    logic [2:0]  sclk_sync = 3'b000;
    logic [2:0]  cs_sync   = 3'b111;
    logic [15:0] slave_sr  = 16'h0000;
    logic [15:0] slave_word = 16'h0000;

    always @(posedge clk) begin
        sclk_sync <= {sclk_sync[1:0], SPI_clk};
        cs_sync   <= {cs_sync[1:0], cs};
        if (cs_sync[2])
            slave_sr <= slave_word;
        else if (sclk_sync[2] && !sclk_sync[1])
            slave_sr <= {slave_sr[14:0], 1'b0};
    end
    assign MISO = slave_sr[15];

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_valid actual data_out=%h frame_err=%b required none", data_out, frame_err);
            end else begin
                logic [12:0] exp;
                exp = sb.pop_front();
                if ({frame_err, data_out} !== exp) begin
                    errors++;
                    $display("FAIL sb_data actual err=%b data=%h required err=%b data=%h",
                             frame_err, data_out, exp[12], exp[11:0]);
                end
            end
        end
    end

    // ---------------- helpers (no comparisons) ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] expect_of(input logic [15:0] w);
        return {|w[15:12], w[11:0]};
    endfunction

    // Called on a sample where cs is low; returns when cs goes high again.
    task automatic watch_frame(input int budget, output int low_cycles, output int rises,
                               output logic dv_at_cs_rise, output bit ok);
        logic prev;
        low_cycles = 0; rises = 0; dv_at_cs_rise = 1'b0; ok = 1'b0;
        prev = SPI_clk;
        for (int i = 0; i < budget; i++) begin
            if (cs == 1'b0) begin
                low_cycles++;
                if (SPI_clk && !prev) rises++;
            end else begin
                dv_at_cs_rise = data_valid;
                ok = 1'b1;
                break;
            end
            prev = SPI_clk;
            cyc();
        end
    endtask

    // Called on the sample where cs rose; counts busy&cs-high cycles.
    task automatic count_gap(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cs == 1'b1 && busy == 1'b1) begin
                n++;
                cyc();
            end else begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; continuous = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if ({SPI_clk, cs, data_out, data_valid, frame_err, busy} !== {1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d actual sclk=%b cs=%b data=%h dv=%b err=%b busy=%b required 0 1 000 0 0 0",
                         i, SPI_clk, cs, data_out, data_valid, frame_err, busy);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        cyc();
        checks++;
        if (busy !== 1'b0 || cs !== 1'b1) begin
            errors++;
            $display("FAIL reset_start_ignored actual busy=%b cs=%b required 0 1", busy, cs);
        end
    endtask

    task automatic run_one_frame(input logic [15:0] word, input string name);
        int low, rises, gap, dv0;
        logic dvr;
        bit ok;
        slave_word = word;
        sb.push_back(expect_of(word));
        dv0 = dv_count;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (cs !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_start_latency actual cs=%b busy=%b required 0 1", name, cs, busy);
        end
        watch_frame(2000, low, rises, dvr, ok);
        checks++;
        if (!ok || low != 33*HP) begin
            errors++;
            $display("FAIL %s_cs_low actual %0d cycles (ok=%0d) required %0d", name, low, ok, 33*HP);
        end
        checks++;
        if (rises != 16) begin
            errors++;
            $display("FAIL %s_rises actual %0d required 16", name, rises);
        end
        checks++;
        if (dvr !== 1'b1) begin
            errors++;
            $display("FAIL %s_dv_at_cs_rise actual %b required 1", name, dvr);
        end
        count_gap(200, gap, ok);
        checks++;
        if (!ok || gap != GAP || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_fall actual %0d cycles busy=%b required %0d busy=0", name, gap, busy, GAP);
        end
        cyc();
        checks++;
        if (dv_count - dv0 != 1 || data_out !== word[11:0] || frame_err !== (|word[15:12])) begin
            errors++;
            $display("FAIL %s_hold actual pulses=%0d data=%h err=%b required 1 %h %b",
                     name, dv_count - dv0, data_out, frame_err, word[11:0], |word[15:12]);
        end
    endtask

    task automatic test_single_frame();
        run_one_frame(16'h0A5C, "single");
    endtask

    task automatic test_error_nibble();
        run_one_frame(16'hF123, "errnib");
    endtask

    task automatic test_continuous();
        int t1, t2, gap;
        bit ok;
        slave_word = 16'h0001;
        sb.push_back(expect_of(16'h0001));
        sb.push_back(expect_of(16'h0FFF));
        continuous = 1'b1;
        cyc();
        checks++;
        if (cs !== 1'b0) begin
            errors++;
            $display("FAIL cont_start actual cs=%b required 0", cs);
        end
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (SPI_clk === 1'b1) begin ok = 1'b1; break; end
            cyc();
        end
        slave_word = 16'h0FFF;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (data_valid === 1'b1) begin ok = 1'b1; break; end
            cyc();
        end
        t1 = cycle_no;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cont_dv1_timeout actual none required pulse");
        end
        count_gap(200, gap, ok);
        checks++;
        if (!ok || gap != GAP || cs !== 1'b0) begin
            errors++;
            $display("FAIL cont_gap actual %0d cycles cs=%b required %0d cs=0", gap, cs, GAP);
        end
        continuous = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (data_valid === 1'b1) begin ok = 1'b1; break; end
            cyc();
        end
        t2 = cycle_no;
        checks++;
        if (!ok || t2 - t1 != 33*HP + GAP) begin
            errors++;
            $display("FAIL cont_period actual %0d (ok=%0d) required %0d", t2 - t1, ok, 33*HP + GAP);
        end
        count_gap(200, gap, ok);
        checks++;
        if (!ok || gap != GAP || busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_stop actual gap=%0d busy=%b required %0d busy=0", gap, busy, GAP);
        end
    endtask

    task automatic test_abort();
        int rises, dv0;
        logic prev;
        bit ok;
        slave_word = 16'h0BCD;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        rises = 0; ok = 1'b0;
        prev = SPI_clk;
        for (int i = 0; i < 1000; i++) begin
            if (SPI_clk && !prev) rises++;
            if (rises == 7) begin ok = 1'b1; break; end
            prev = SPI_clk;
            cyc();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_reach_rise7 actual %0d rises required 7", rises);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        checks++;
        if ({cs, SPI_clk, data_valid, data_out, busy} !== {1'b1, 1'b0, 1'b0, 12'h000, 1'b0}) begin
            errors++;
            $display("FAIL abort_reset actual cs=%b sclk=%b dv=%b data=%h busy=%b required 1 0 0 000 0",
                     cs, SPI_clk, data_valid, data_out, busy);
        end
        dv0 = dv_count;
        repeat (40) cyc();
        checks++;
        if (dv_count != dv0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet actual pulses=%0d busy=%b required 0 0", dv_count - dv0, busy);
        end
        run_one_frame(16'h05A5, "after_abort");
    endtask

    task automatic test_ignored_start();
        int rises, low, gap, dv0;
        logic prev, dvr;
        bit ok;
        slave_word = 16'h0321;
        sb.push_back(expect_of(16'h0321));
        dv0 = dv_count;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        rises = 0; ok = 1'b0;
        prev = SPI_clk;
        for (int i = 0; i < 1000; i++) begin
            if (SPI_clk && !prev) rises++;
            if (rises == 3 && SPI_clk) begin ok = 1'b1; break; end
            prev = SPI_clk;
            cyc();
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        checks++;
        if (!ok || SPI_clk !== 1'b1) begin
            errors++;
            $display("FAIL ign_in_high actual ok=%0d sclk=%b required 1 1", ok, SPI_clk);
        end
        watch_frame(2000, low, rises, dvr, ok);
        count_gap(200, gap, ok);
        checks++;
        if (!ok || gap != GAP || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_busy_fall actual %0d cycles busy=%b required %0d busy=0", gap, busy, GAP);
        end
        low = 0;
        for (int i = 0; i < 300; i++) begin
            if (cs == 1'b0) low++;
            cyc();
        end
        checks++;
        if (low != 0 || dv_count - dv0 != 1) begin
            errors++;
            $display("FAIL ign_no_extra actual cs_low=%0d pulses=%0d required 0 1", low, dv_count - dv0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0;
        test_reset();
        test_single_frame();
        test_error_nibble();
        test_continuous();
        test_abort();
        test_ignored_start();
        repeat (5) cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover actual %0d entries required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
